motion_y_ctrl: RTL

//  Parametrised vertical-motion generator for player/enemy sprites. Fixed-point velocity accumulator

---
 rtl/motion_y_ctrl_pkg.sv | 24 ++
 rtl/motion_y_ctrl_if.sv | 27 ++
 rtl/motion_y_ctrl_rise_det.sv | 17 +
 rtl/motion_y_ctrl.sv | 104 ++++++++++
 4 files changed

// File: rtl/motion_y_ctrl_pkg.sv
// Shared types and fixed-point helpers for the vertical motion controller.
// Exports the motion state encoding plus to_fix/sat_add arithmetic helpers.
package motion_pkg;

    typedef enum logic [1:0] {
        GROUNDED = 2'd0,
        RISING   = 2'd1,
        FALLING  = 2'd2
    } motion_state_t;

    // Integer pixels to fixed point with frac fractional bits.
    function automatic int to_fix(input int px, input int frac);
        return px <<< frac;
    endfunction

    // Add, then clamp against an upper bound.
    // int is wider than any velocity, so the sum cannot wrap.
    function automatic int sat_add(input int a, input int b, input int hi);
        int s;
        s = a + b;
        return (s > hi) ? hi : s;
    endfunction

endpackage

// File: rtl/motion_y_ctrl_if.sv
// Frame-control and motion-output bundle for one sprite's vertical motion.
// master: drives Step_en/Jump/Grd_hit/Ceil_hit/Freeze; slave: drives Y_Move/Airborne/Jumps_left.
interface motion_y_ctrl_if #(
    parameter int W         = 10,
    parameter int MAX_JUMPS = 2
);
    localparam int JW = $clog2(MAX_JUMPS + 1);

    logic          Step_en;
    logic          Jump;
    logic          Grd_hit;
    logic          Ceil_hit;
    logic          Freeze;
    logic [W-1:0]  Y_Move;
    logic          Airborne;
    logic [JW-1:0] Jumps_left;

    modport master (
        output Step_en, Jump, Grd_hit, Ceil_hit, Freeze,
        input  Y_Move, Airborne, Jumps_left
    );

    modport slave (
        input  Step_en, Jump, Grd_hit, Ceil_hit, Freeze,
        output Y_Move, Airborne, Jumps_left
    );
endinterface

// File: rtl/motion_y_ctrl_rise_det.sv
// Registered rising-edge detector: rise = D & ~D(previous CLK).
// Ports: CLK, Reset_n (async active-low), D in, Rise out.
module rise_det (
    input  logic CLK,
    input  logic Reset_n,
    input  logic D,
    output logic Rise
);
    logic d_q;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) d_q <= 1'b0;
        else          d_q <= D;
    end

    assign Rise = D & ~d_q;
endmodule

// File: rtl/motion_y_ctrl.sv
// Vertical motion generator: gravity, jump impulse, terminal clamp, jump budget, ceiling bounce.
// Ports: CLK, Reset_n (async active-low), bus (motion_y_ctrl_if.slave).
module motion_y_ctrl
    import motion_pkg::*;
#(
    parameter int W         = 10,
    parameter int FRAC      = 4,
    parameter int GRAVITY   = 6,
    parameter int JUMP_VEL  = 7,
    parameter int VMAX_DOWN = 8,
    parameter int MAX_JUMPS = 2
) (
    input logic           CLK,
    input logic           Reset_n,
    motion_y_ctrl_if.slave bus
);
    localparam int VW = W + FRAC;
    localparam int JW = $clog2(MAX_JUMPS + 1);

    localparam logic signed [VW-1:0] V_JUMP = VW'(-to_fix(JUMP_VEL, FRAC));
    localparam int                   V_MAX  = to_fix(VMAX_DOWN, FRAC);
    localparam logic [JW-1:0]        J_MAX  = JW'(MAX_JUMPS);
    localparam logic [JW-1:0]        J_AIR  = JW'(MAX_JUMPS - 1);

    motion_state_t         state, state_n;
    logic signed [VW-1:0]  vel, vel_n, vel_grav;
    logic [JW-1:0]         jl, jl_n;
    logic                  pend, pend_n;
    logic                  rise;
    logic                  jump_ok;

    rise_det u_rise (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .D       (bus.Jump),
        .Rise    (rise)
    );

    // An edge arriving on the step cycle itself still counts.
    assign jump_ok  = (pend | rise) && (jl != '0);
    assign vel_grav = VW'(sat_add(int'(vel), GRAVITY, V_MAX));

    always_comb begin
        state_n = state;
        vel_n   = vel;
        jl_n    = jl;
        pend_n  = pend | rise;
        if (bus.Freeze) begin
            pend_n = 1'b0;
        end else if (bus.Step_en) begin
            pend_n = 1'b0;
            if (state == GROUNDED) begin
                if (jump_ok) begin
                    state_n = RISING;
                    vel_n   = V_JUMP;
                    jl_n    = jl - 1'b1;
                end else if (!bus.Grd_hit) begin
                    // Walked off a ledge: the ground jump is spent.
                    state_n = FALLING;
                    vel_n   = '0;
                    jl_n    = J_AIR;
                end else begin
                    vel_n = '0;
                    jl_n  = J_MAX;
                end
            end else begin
                if (jump_ok) begin
                    state_n = RISING;
                    vel_n   = V_JUMP;
                    jl_n    = jl - 1'b1;
                end else if (bus.Ceil_hit && vel < 0) begin
                    state_n = FALLING;
                    vel_n   = '0;
                end else if (bus.Grd_hit && vel >= 0) begin
                    state_n = GROUNDED;
                    vel_n   = '0;
                    jl_n    = J_MAX;
                end else begin
                    vel_n   = vel_grav;
                    state_n = (vel_grav < 0) ? RISING : FALLING;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= GROUNDED;
            vel   <= '0;
            jl    <= J_MAX;
            pend  <= 1'b0;
        end else begin
            state <= state_n;
            vel   <= vel_n;
            jl    <= jl_n;
            pend  <= pend_n;
        end
    end

    // Upper bits of vel are the floored arithmetic shift by FRAC.
    assign bus.Y_Move     = bus.Freeze ? '0 : vel[VW-1:FRAC];
    assign bus.Airborne   = (state != GROUNDED);
    assign bus.Jumps_left = jl;
endmodule
